// File: rtl/sr_dbg_dumper_pkg.sv
// Shared definitions for the debug register dumper: FSM state encoding,
// default frame header byte and a frame length helper.
package sr_dbg_dumper_pkg;

    typedef enum logic [2:0] {
        DBG_IDLE = 3'd0,
        DBG_HDR  = 3'd1,
        DBG_LOAD = 3'd2,
        DBG_SEND = 3'd3,
        DBG_DONE = 3'd4
    } dbg_state_t;

    localparam logic [7:0] DBG_SYNC_BYTE = 8'hA5;

    // One header byte plus four bytes per dumped register.
    function automatic int unsigned dbg_frame_bytes(input int unsigned first_reg,
                                                    input int unsigned last_reg);
        return 1 + 4 * (last_reg - first_reg + 1);
    endfunction

endpackage

// File: rtl/sr_dbg_dumper_if.sv
// Byte stream from the dumper to a UART or trace sink, valid/ready handshake.
interface sr_dbg_dumper_if;

    logic       m_valid;
    logic       m_ready;
    logic [7:0] m_data;

    modport master (output m_valid, output m_data, input m_ready);
    modport slave  (input m_valid, input m_data, output m_ready);

endinterface

// File: rtl/sr_dbg_ser.sv
// Splits a captured 32-bit register value into four bytes, least significant first.
module sr_dbg_ser
    import sr_dbg_dumper_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load,
    input  logic [31:0] word,
    input  logic        enable,
    input  logic        ready,
    output logic        valid,
    output logic [7:0]  data,
    output logic        last
);

    logic [31:0] shift;
    logic [1:0]  count;

    // The count wraps to zero after the fourth byte, so the next load starts clean either way.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shift <= '0;
            count <= '0;
        end else if (load) begin
            shift <= word;
            count <= '0;
        end else if (enable && ready) begin
            shift <= {8'h00, shift[31:8]};
            count <= count + 2'd1;
        end
    end

    assign valid = enable;
    assign data  = shift[7:0];
    assign last  = (count == 2'd3);

endmodule

// File: rtl/sr_dbg_dumper.sv
// Walks the CPU debug register port on a start pulse and streams a framed
// dump (header byte, then every register LSB first) over a byte interface.
module sr_dbg_dumper
    import sr_dbg_dumper_pkg::*;
#(
    parameter int unsigned FIRST_REG = 0,
    parameter int unsigned LAST_REG  = 31,
    parameter logic [7:0]  SYNC_BYTE = DBG_SYNC_BYTE
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    output logic                  busy,
    output logic                  done,
    output logic [4:0]            regAddr,
    input  logic [31:0]           regData,
    sr_dbg_dumper_if.master       m
);

    localparam logic [4:0] FIRST_IDX = 5'(FIRST_REG);
    localparam logic [4:0] LAST_IDX  = 5'(LAST_REG);

    dbg_state_t state;
    dbg_state_t state_next;
    logic [4:0] index;
    logic       ser_load;
    logic       ser_enable;
    logic       ser_valid;
    logic       ser_last;
    logic [7:0] ser_data;

    sr_dbg_ser u_ser (
        .clk    (clk),
        .rst_n  (rst_n),
        .load   (ser_load),
        .word   (regData),
        .enable (ser_enable),
        .ready  (m.m_ready),
        .valid  (ser_valid),
        .data   (ser_data),
        .last   (ser_last)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= DBG_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        ser_load   = 1'b0;
        ser_enable = 1'b0;
        m.m_valid  = 1'b0;
        m.m_data   = 8'h00;
        busy       = 1'b1;
        done       = 1'b0;
        case (state)
            DBG_IDLE: begin
                busy = 1'b0;
                if (start) begin
                    state_next = DBG_HDR;
                end
            end
            DBG_HDR: begin
                m.m_valid = 1'b1;
                m.m_data  = SYNC_BYTE;
                if (m.m_ready) begin
                    state_next = DBG_LOAD;
                end
            end
            // regData settles from the address set on the previous edge and is captured here.
            DBG_LOAD: begin
                ser_load   = 1'b1;
                state_next = DBG_SEND;
            end
            DBG_SEND: begin
                ser_enable = 1'b1;
                m.m_valid  = ser_valid;
                m.m_data   = ser_data;
                if (ser_valid && m.m_ready && ser_last) begin
                    state_next = (index == LAST_IDX) ? DBG_DONE : DBG_LOAD;
                end
            end
            DBG_DONE: begin
                done       = 1'b1;
                state_next = DBG_IDLE;
            end
            default: begin
                state_next = DBG_IDLE;
            end
        endcase
    end

    // Index stops at LAST_IDX, so the 5-bit increment never wraps.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            index   <= FIRST_IDX;
            regAddr <= 5'd0;
        end else begin
            case (state)
                DBG_IDLE: begin
                    if (start) begin
                        index <= FIRST_IDX;
                    end
                end
                DBG_HDR: begin
                    if (m.m_ready) begin
                        regAddr <= index;
                    end
                end
                DBG_SEND: begin
                    if (m.m_ready && ser_last && (index != LAST_IDX)) begin
                        index   <= index + 5'd1;
                        regAddr <= index + 5'd1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sr_dbg_dumper.sv
// Bench for sr_dbg_dumper: a full-range dumper and a two-register dumper,
// each checked every cycle against a frame model plus literal stream checks.
module tb_sr_dbg_dumper;
    import sr_dbg_dumper_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start_s [2];
    logic        ready_s [2];
    logic [31:0] core [2][32];
    logic [1:0]  busy_w;
    logic [1:0]  done_w;
    logic [1:0]  valid_w;
    logic [7:0]  data_w [2];
    logic [4:0]  addr_w [2];
    logic [31:0] reg_data [2];

    int checks = 0;
    int errors = 0;
    int busy_cnt [2];
    int done_cnt [2];
    logic [7:0] rx0 [$];
    logic [7:0] rx1 [$];
    logic [4:0] addr_log1 [$];
    logic [7:0] pair_stream [9];
    logic [4:0] addr_before;

    sr_dbg_dumper_if bus0();
    sr_dbg_dumper_if bus1();

    assign bus0.m_ready = ready_s[0];
    assign bus1.m_ready = ready_s[1];
    assign valid_w[0]   = bus0.m_valid;
    assign valid_w[1]   = bus1.m_valid;
    assign data_w[0]    = bus0.m_data;
    assign data_w[1]    = bus1.m_data;
    assign reg_data[0]  = core[0][addr_w[0]];
    assign reg_data[1]  = core[1][addr_w[1]];

    sr_dbg_dumper dut_full (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start_s[0]),
        .busy    (busy_w[0]),
        .done    (done_w[0]),
        .regAddr (addr_w[0]),
        .regData (reg_data[0]),
        .m       (bus0.master)
    );

    sr_dbg_dumper #(.FIRST_REG(5), .LAST_REG(6)) dut_pair (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start_s[1]),
        .busy    (busy_w[1]),
        .done    (done_w[1]),
        .regAddr (addr_w[1]),
        .regData (reg_data[1]),
        .m       (bus1.master)
    );

    always #5 clk = ~clk;

    task automatic check_output(input string name, input logic [31:0] actual,
                                input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h, expected %h at %0t", name, actual, expected, $time);
        end
    endtask

    // Frame model: expected bytes come from the core register values seen in the
    // cycle right after each register's predecessor finished (its sampling cycle).
    task automatic monitor(input int l);
        int         first = (l == 0) ? 0 : 5;
        int         nregs = (l == 0) ? 32 : 2;
        int         total = 1 + 4 * nregs;
        int         pos = 0;
        int         pend_reg = 0;
        bit         pend = 0;
        bit         exp_done = 0;
        bit         busy_m = 0;
        bit         next_busy;
        bit         stalled = 0;
        logic [7:0] held = 8'h00;
        logic [7:0] want;
        logic [4:0] last_addr = 5'd0;
        logic [7:0] expq [$];
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                pos = 0; pend = 0; exp_done = 0; busy_m = 0; stalled = 0; last_addr = 5'd0;
                expq.delete();
                check_output("rst_valid", 32'(valid_w[l]), 32'd0);
                check_output("rst_busy", 32'(busy_w[l]), 32'd0);
                check_output("rst_done", 32'(done_w[l]), 32'd0);
                check_output("rst_data", 32'(data_w[l]), 32'd0);
                check_output("rst_addr", 32'(addr_w[l]), 32'd0);
                continue;
            end
            check_output("done", 32'(done_w[l]), 32'(exp_done));
            check_output("busy", 32'(busy_w[l]), 32'(busy_m));
            if (busy_w[l]) busy_cnt[l]++;
            if (done_w[l]) done_cnt[l]++;
            if (pend) begin
                check_output("load_gap", 32'(valid_w[l]), 32'd0);
                for (int b = 0; b < 4; b++) expq.push_back(core[l][pend_reg][8*b +: 8]);
                pend = 0;
            end
            if (stalled) begin
                check_output("hold_valid", 32'(valid_w[l]), 32'd1);
                check_output("hold_data", 32'(data_w[l]), 32'(held));
            end
            if (exp_done || !busy_m) check_output("valid_quiet", 32'(valid_w[l]), 32'd0);
            next_busy = busy_m;
            if (exp_done) next_busy = 1'b0;
            else if (!busy_m && start_s[l]) next_busy = 1'b1;
            exp_done = 0;
            if (addr_w[l] != last_addr) begin
                if (l == 1) addr_log1.push_back(addr_w[l]);
                last_addr = addr_w[l];
            end
            if (valid_w[l] && ready_s[l]) begin
                if (pos == 0) begin
                    want = DBG_SYNC_BYTE;
                end else begin
                    check_output("byte_avail", 32'(expq.size() != 0), 32'd1);
                    want = (expq.size() != 0) ? expq.pop_front() : 8'h00;
                end
                check_output("byte", 32'(data_w[l]), 32'(want));
                if (l == 0) rx0.push_back(data_w[l]);
                else rx1.push_back(data_w[l]);
                if ((pos % 4 == 0) && (pos / 4 < nregs)) begin
                    pend = 1;
                    pend_reg = first + pos / 4;
                end
                pos++;
                if (pos == total) begin
                    pos = 0;
                    exp_done = 1;
                end
                stalled = 0;
            end else begin
                stalled = valid_w[l];
            end
            held = data_w[l];
            busy_m = next_busy;
        end
    endtask

    task automatic apply_stimulus(input int l);
        @(posedge clk);
        #1 start_s[l] = 1'b1;
        @(posedge clk);
        #1 start_s[l] = 1'b0;
    endtask

    task automatic wait_done(input int l, input int budget);
        int base = done_cnt[l];
        for (int i = 0; i < budget; i++) begin
            @(posedge clk);
            if (done_cnt[l] > base) break;
        end
        check_output("wait_done", 32'(done_cnt[l] > base), 32'd1);
    endtask

    task automatic wait_rx(input int l, input int n, input int budget);
        for (int i = 0; i < budget; i++) begin
            @(posedge clk);
            if (((l == 0) ? rx0.size() : rx1.size()) >= n) break;
        end
        check_output("wait_rx", 32'(((l == 0) ? rx0.size() : rx1.size()) >= n), 32'd1);
    endtask

    task automatic init_core();
        for (int i = 0; i < 32; i++) begin
            core[0][i] = (i == 0) ? 32'h0000_0040 : 32'h1000_0000 + 32'(i);
            core[1][i] = 32'hDEAD_BEEF;
        end
    endtask

    initial begin
        int base;
        pair_stream = '{8'hA5, 8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
        for (int l = 0; l < 2; l++) begin
            start_s[l]  = 1'b0;
            ready_s[l]  = 1'b1;
            busy_cnt[l] = 0;
            done_cnt[l] = 0;
        end
        init_core();
        fork
            monitor(0);
            monitor(1);
        join_none

        #2;
        check_output("reset_busy", 32'(busy_w[0]), 32'd0);
        check_output("reset_valid", 32'(valid_w[0]), 32'd0);
        check_output("reset_data", 32'(data_w[0]), 32'd0);
        check_output("reset_addr", 32'(addr_w[0]), 32'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        $display("[TB] full range frame, sink always ready");
        busy_cnt[0] = 0;
        done_cnt[0] = 0;
        apply_stimulus(0);
        wait_done(0, 400);
        check_output("t1_len", 32'(rx0.size()), 32'd129);
        if (rx0.size() == 129) begin
            check_output("t1_hdr", 32'(rx0[0]), 32'hA5);
            check_output("t1_pc0", 32'(rx0[1]), 32'h40);
            check_output("t1_pc1", 32'(rx0[2]), 32'h00);
            check_output("t1_r1b0", 32'(rx0[5]), 32'h01);
            check_output("t1_r1b3", 32'(rx0[8]), 32'h10);
            check_output("t1_r31b0", 32'(rx0[125]), 32'h1F);
            check_output("t1_r31b3", 32'(rx0[128]), 32'h10);
        end
        check_output("t1_busy_cycles", 32'(busy_cnt[0]), 32'd162);
        check_output("t1_done_pulses", 32'(done_cnt[0]), 32'd1);

        $display("[TB] two register frame, sink ready toggling");
        base = done_cnt[1];
        @(posedge clk);
        #1 start_s[1] = 1'b1;
        for (int i = 0; i < 100; i++) begin
            @(posedge clk);
            #1 start_s[1] = 1'b0;
            ready_s[1] = ~ready_s[1];
            if (done_cnt[1] > base) break;
        end
        ready_s[1] = 1'b1;
        check_output("t2_done", 32'(done_cnt[1] > base), 32'd1);
        check_output("t2_len", 32'(rx1.size()), 32'd9);
        if (rx1.size() == 9)
            for (int i = 0; i < 9; i++) check_output("t2_byte", 32'(rx1[i]), 32'(pair_stream[i]));
        check_output("t2_addr_steps", 32'(addr_log1.size()), 32'd2);
        if (addr_log1.size() == 2) begin
            check_output("t2_addr_first", 32'(addr_log1[0]), 32'd5);
            check_output("t2_addr_second", 32'(addr_log1[1]), 32'd6);
        end

        $display("[TB] header stalled for 20 cycles");
        rx0.delete();
        ready_s[0] = 1'b0;
        addr_before = addr_w[0];
        apply_stimulus(0);
        for (int i = 0; i < 20; i++) begin
            check_output("t3_valid", 32'(valid_w[0]), 32'd1);
            check_output("t3_data", 32'(data_w[0]), 32'hA5);
            check_output("t3_addr", 32'(addr_w[0]), 32'(addr_before));
            @(posedge clk);
            #1;
        end
        ready_s[0] = 1'b1;
        wait_done(0, 400);
        check_output("t3_len", 32'(rx0.size()), 32'd129);

        $display("[TB] reset in the middle of register 3");
        rx0.delete();
        apply_stimulus(0);
        wait_rx(0, 15, 200);
        #1 rst_n = 1'b0;
        #1;
        check_output("t4_valid", 32'(valid_w[0]), 32'd0);
        check_output("t4_busy", 32'(busy_w[0]), 32'd0);
        check_output("t4_done", 32'(done_w[0]), 32'd0);
        check_output("t4_addr", 32'(addr_w[0]), 32'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        rx0.delete();
        apply_stimulus(0);
        wait_done(0, 400);
        check_output("t4_len", 32'(rx0.size()), 32'd129);
        if (rx0.size() != 0) check_output("t4_hdr", 32'(rx0[0]), 32'hA5);

        $display("[TB] start pulses during SEND and DONE");
        rx0.delete();
        done_cnt[0] = 0;
        apply_stimulus(0);
        wait_rx(0, 10, 200);
        #1 start_s[0] = 1'b1;
        @(posedge clk);
        #1 start_s[0] = 1'b0;
        wait_rx(0, 129, 800);
        #1 start_s[0] = 1'b1;
        @(posedge clk);
        #1 start_s[0] = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        check_output("t5_done_pulses", 32'(done_cnt[0]), 32'd1);
        check_output("t5_len", 32'(rx0.size()), 32'd129);
        check_output("t5_idle", 32'(busy_w[0]), 32'd0);

        $display("[TB] core registers change mid-frame");
        rx0.delete();
        apply_stimulus(0);
        wait_rx(0, 6, 200);
        #1;
        core[0][1] = 32'h1111_1111;
        core[0][2] = 32'hCAFE_F00D;
        wait_done(0, 400);
        if (rx0.size() == 129) begin
            check_output("t6_r1b0", 32'(rx0[5]), 32'h01);
            check_output("t6_r1b3", 32'(rx0[8]), 32'h10);
            check_output("t6_r2b0", 32'(rx0[9]), 32'h0D);
            check_output("t6_r2b1", 32'(rx0[10]), 32'hF0);
            check_output("t6_r2b2", 32'(rx0[11]), 32'hFE);
            check_output("t6_r2b3", 32'(rx0[12]), 32'hCA);
        end else begin
            check_output("t6_len", 32'(rx0.size()), 32'd129);
        end
        init_core();

        repeat (3) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
